// File: rtl/router_pkg.sv
// Shared definitions for the mesh router: port numbering, header field layout and XY routing.
package router_pkg;

    localparam int unsigned CHANNEL_NUMBER = 5;

    typedef enum logic [2:0] {
        PortLocal = 3'd0,
        PortNorth = 3'd1,
        PortSouth = 3'd2,
        PortEast  = 3'd3,
        PortWest  = 3'd4
    } port_e;

    typedef enum logic {StIdle, StBusy} alloc_state_e;

    function automatic int unsigned x_lo();
        return 0;
    endfunction

    function automatic int unsigned y_lo(input int unsigned xw);
        return xw;
    endfunction

    function automatic int unsigned len_lo(input int unsigned xw, input int unsigned yw);
        return xw + yw;
    endfunction

    // X is resolved first; Y only once the packet is in the right column.
    function automatic port_e xy_route(input int unsigned x, input int unsigned y,
                                       input int unsigned rx, input int unsigned ry);
        if (x > rx) return PortEast;
        if (x < rx) return PortWest;
        if (y > ry) return PortNorth;
        if (y < ry) return PortSouth;
        return PortLocal;
    endfunction

    // Reduces 0..9 into 0..4 so port indices never rely on a natural overflow.
    function automatic logic [2:0] wrap5(input logic [3:0] v);
        return (v >= 4'd5) ? 3'(v - 4'd5) : v[2:0];
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker over the five input channels, starting the search at ptr.
module rr_picker
    import router_pkg::*;
(
    input  logic [CHANNEL_NUMBER-1:0] request,
    input  logic [2:0]                ptr,
    output logic                      grant_valid,
    output logic [2:0]                grant_idx
);

    // Scan from the farthest offset down so the closest requester to ptr is written last.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = CHANNEL_NUMBER - 1; k >= 0; k--) begin
            if (request[wrap5({1'b0, ptr} + 4'(k))]) begin
                grant_valid = 1'b1;
                grant_idx   = wrap5({1'b0, ptr} + 4'(k));
            end
        end
    end

endmodule

// File: rtl/xy_switch_allocator.sv
// Switch allocator: XY-routes each waiting header and binds outputs to inputs for a whole packet.
module xy_switch_allocator
    import router_pkg::*;
#(
    parameter int unsigned DATA_WIDTH              = 32,
    parameter int unsigned MAX_ROUTERS_X           = 4,
    parameter int unsigned MAX_ROUTERS_Y           = 4,
    parameter int unsigned MAXIMUM_PACKAGES_NUMBER = 5,
    parameter int unsigned ROUTER_X                = 0,
    parameter int unsigned ROUTER_Y                = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [CHANNEL_NUMBER-1:0]            in_valid,
    input  logic [CHANNEL_NUMBER*DATA_WIDTH-1:0] in_data,
    input  logic [CHANNEL_NUMBER-1:0]            out_ready,
    output logic [CHANNEL_NUMBER*3-1:0]          out_sel,
    output logic [CHANNEL_NUMBER-1:0]            out_lock,
    output logic [CHANNEL_NUMBER-1:0]            in_bound
);

    localparam int unsigned XW  = $clog2(MAX_ROUTERS_X);
    localparam int unsigned YW  = $clog2(MAX_ROUTERS_Y);
    localparam int unsigned LW  = $clog2(MAXIMUM_PACKAGES_NUMBER);
    localparam int unsigned XLO = x_lo();
    localparam int unsigned YLO = y_lo(XW);
    localparam int unsigned LLO = len_lo(XW, YW);

    logic [2:0]                route   [CHANNEL_NUMBER];
    logic [LW-1:0]             hdr_len [CHANNEL_NUMBER];
    logic [CHANNEL_NUMBER-1:0] req     [CHANNEL_NUMBER];

    // Only the header fields matter here; the rest of TDATA passes through the crossbar.
    logic unused_data;
    assign unused_data = ^in_data;

    for (genvar i = 0; i < CHANNEL_NUMBER; i++) begin : g_in
        logic [XW-1:0] hx;
        logic [YW-1:0] hy;
        assign hx         = in_data[i*DATA_WIDTH + XLO +: XW];
        assign hy         = in_data[i*DATA_WIDTH + YLO +: YW];
        assign hdr_len[i] = in_data[i*DATA_WIDTH + LLO +: LW];
        assign route[i]   = xy_route(32'(hx), 32'(hy), ROUTER_X, ROUTER_Y);
    end

    always_comb begin
        in_bound = '0;
        for (int o = 0; o < CHANNEL_NUMBER; o++) begin
            for (int i = 0; i < CHANNEL_NUMBER; i++) begin
                if (out_lock[o] && (out_sel[o*3 +: 3] == 3'(i))) in_bound[i] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int o = 0; o < CHANNEL_NUMBER; o++) begin
            for (int i = 0; i < CHANNEL_NUMBER; i++) begin
                req[o][i] = in_valid[i] && !in_bound[i] && (route[i] == 3'(o));
            end
        end
    end

    for (genvar o = 0; o < CHANNEL_NUMBER; o++) begin : g_out
        alloc_state_e  state_q, state_d;
        logic [2:0]    sel_q, sel_d, rr_q, rr_d;
        logic [LW-1:0] cnt_q, cnt_d;
        logic          grant_valid;
        logic [2:0]    grant_idx;
        logic          beat;

        rr_picker u_pick (
            .request     (req[o]),
            .ptr         (rr_q),
            .grant_valid (grant_valid),
            .grant_idx   (grant_idx)
        );

        assign beat = in_valid[sel_q] && out_ready[o];

        // Grants happen only from IDLE, which leaves a one-cycle bubble after each release.
        always_comb begin
            state_d = state_q;
            sel_d   = sel_q;
            cnt_d   = cnt_q;
            rr_d    = rr_q;
            unique case (state_q)
                StIdle: begin
                    if (grant_valid) begin
                        sel_d   = grant_idx;
                        cnt_d   = hdr_len[grant_idx];
                        state_d = StBusy;
                    end
                end
                StBusy: begin
                    if (beat) begin
                        if (cnt_q == '0) begin
                            state_d = StIdle;
                            rr_d    = wrap5({1'b0, sel_q} + 4'd1);
                        end else begin
                            cnt_d = cnt_q - LW'(1);
                        end
                    end
                end
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= StIdle;
                sel_q   <= '0;
                cnt_q   <= '0;
                rr_q    <= '0;
            end else begin
                state_q <= state_d;
                sel_q   <= sel_d;
                cnt_q   <= cnt_d;
                rr_q    <= rr_d;
            end
        end

        assign out_sel[o*3 +: 3] = sel_q;
        assign out_lock[o]       = (state_q == StBusy);
    end

endmodule
